// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: PC offer, instruction-memory req/gnt/rvalid,
// decode-side valid/ready and the sticky error flag.
interface fetch_queue_if #(
  parameter int ADDR_W = 32
) ();
  logic              pc_valid_i;
  logic [ADDR_W-1:0] pc_i;
  logic              pc_ready_o;
  logic              flush_i;
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_gnt_i;
  logic              imem_rvalid_i;
  logic [31:0]       imem_rdata_i;
  logic              instr_valid_o;
  logic [31:0]       instr_o;
  logic [ADDR_W-1:0] instr_pc_o;
  logic              instr_ready_i;
  logic              err_o;

  modport master (
    output pc_valid_i, pc_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    input  pc_ready_o, imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, err_o
  );

  modport slave (
    input  pc_valid_i, pc_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    output pc_ready_o, imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, err_o
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch queue: issues PCs to instruction memory, buffers in-order responses
// as {pc, instr} entries for decode; flush drops queue and in-flight fetches.
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  fetch_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc_q  [DEPTH];
  logic [31:0]       ins_q [DEPTH];
  logic [DEPTH-1:0]  filled;
  logic [PW-1:0]     wr_ptr, fill_ptr, rd_ptr;
  logic [CW-1:0]     count, unfilled, drop_cnt;
  logic              err;

  logic [CW:0] pend;
  logic        space, req, accept, vld, pop;
  logic        rsp_drop, rsp_fill, rsp_err;

  // Outstanding responses (stale + live) must never exceed DEPTH.
  assign pend   = {1'b0, drop_cnt} + {1'b0, unfilled};
  assign space  = (count < CW'(DEPTH)) && (pend < (CW+1)'(DEPTH));
  assign req    = bus.pc_valid_i && space && !bus.flush_i && !rst;
  assign accept = req && bus.imem_gnt_i;
  assign vld    = (count != '0) && filled[rd_ptr];
  assign pop    = vld && bus.instr_ready_i && !bus.flush_i;

  assign rsp_drop = bus.imem_rvalid_i && !bus.flush_i && (drop_cnt != '0);
  assign rsp_fill = bus.imem_rvalid_i && !bus.flush_i && (drop_cnt == '0) && (unfilled != '0);
  assign rsp_err  = bus.imem_rvalid_i && !bus.flush_i && (drop_cnt == '0) && (unfilled == '0);

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = bus.pc_i;
  assign bus.pc_ready_o    = accept;
  assign bus.instr_valid_o = vld;
  assign bus.instr_o       = ins_q[rd_ptr];
  assign bus.instr_pc_o    = pc_q[rd_ptr];
  assign bus.err_o         = err;

  // Payload storage needs no reset; the filled flags qualify it.
  always_ff @(posedge clk) begin
    if (accept)   pc_q[wr_ptr]    <= bus.pc_i;
    if (rsp_fill) ins_q[fill_ptr] <= bus.imem_rdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      unfilled <= '0;
      drop_cnt <= '0;
      filled   <= '0;
      err      <= 1'b0;
    end else if (bus.flush_i) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      unfilled <= '0;
      filled   <= '0;
      // Every unfilled slot becomes a stale response; one arriving now is already gone.
      drop_cnt <= (pend == '0) ? '0 : CW'(pend - (CW+1)'(bus.imem_rvalid_i));
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr         <= rd_ptr + 1'b1;
        filled[rd_ptr] <= 1'b0;
      end
      if (rsp_fill) begin
        fill_ptr         <= fill_ptr + 1'b1;
        filled[fill_ptr] <= 1'b1;
      end
      count    <= count + CW'(accept) - CW'(pop);
      unfilled <= unfilled + CW'(accept) - CW'(rsp_fill);
      if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
      if (rsp_err)  err      <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Cycle-table bench for fetch_queue: per-cycle handshake checks plus a
// scoreboard of expected {pc, instr} pairs popped as decode consumes them.
module tb_fetch_queue;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_if #(.ADDR_W(32)) bus ();
  fetch_queue #(.DEPTH(4), .ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic        rst, pv;
    logic [31:0] pc;
    logic        gnt, rv;
    logic [31:0] rd;
    logic        rdy, fl;
    logic        e_rdy, e_req, e_vld, e_err;
    logic        psh;
    logic [31:0] spc;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } sb_t;

  int   errors = 0;
  int   checks = 0;
  sb_t  sb[$];
  vec_t tbl[$];

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return 32'hC000_0000 ^ pc;
  endfunction

  function automatic vec_t mk(input logic r, pv, input logic [31:0] pc, input logic gnt, rv,
                              input logic [31:0] rd, input logic rdy, fl, e_rdy, e_req, e_vld,
                              e_err, psh, input logic [31:0] spc);
    vec_t v;
    v = '{r, pv, pc, gnt, rv, rd, rdy, fl, e_rdy, e_req, e_vld, e_err, psh, spc};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    rst               = v.rst;
    bus.pc_valid_i    = v.pv;
    bus.pc_i          = v.pc;
    bus.imem_gnt_i    = v.gnt;
    bus.imem_rvalid_i = v.rv;
    bus.imem_rdata_i  = v.rd;
    bus.instr_ready_i = v.rdy;
    bus.flush_i       = v.fl;
    if (v.psh) sb.push_back('{v.spc, ins_of(v.spc)});
    @(negedge clk);
    chk("pc_ready", 32'(bus.pc_ready_o), 32'(v.e_rdy));
    chk("imem_req", 32'(bus.imem_req_o), 32'(v.e_req));
    chk("instr_valid", 32'(bus.instr_valid_o), 32'(v.e_vld));
    chk("err", 32'(bus.err_o), 32'(v.e_err));
    if (v.e_req) chk("imem_addr", bus.imem_addr_o, v.pc);
  endtask

  // Scoreboard: every committed pop must match the next expected pair.
  always @(negedge clk) begin
    if (!rst && !bus.flush_i && bus.instr_valid_o && bus.instr_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got pc %h instr %h, nothing expected", bus.instr_pc_o, bus.instr_o);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_pc", bus.instr_pc_o, e.pc);
        chk("sb_instr", bus.instr_o, e.ins);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.pc_valid_i = 0; bus.pc_i = 0; bus.imem_gnt_i = 0; bus.imem_rvalid_i = 0;
    bus.imem_rdata_i = 0; bus.instr_ready_i = 0; bus.flush_i = 0;

    // reset state
    tbl.push_back(mk(1,0,0,      1,0,0,           1,0, 0,0,0,0, 0,0));
    tbl.push_back(mk(1,1,32'h4,  1,0,0,           1,0, 0,0,0,0, 0,0));
    // stream: one instruction per cycle, in order
    tbl.push_back(mk(0,1,32'h0,  1,0,0,           1,0, 1,1,0,0, 0,0));
    tbl.push_back(mk(0,1,32'h4,  1,1,ins_of(0),   1,0, 1,1,0,0, 1,32'h0));
    tbl.push_back(mk(0,1,32'h8,  1,1,ins_of(4),   1,0, 1,1,1,0, 1,32'h4));
    tbl.push_back(mk(0,0,0,      1,1,ins_of(8),   1,0, 0,0,1,0, 1,32'h8));
    tbl.push_back(mk(0,0,0,      1,0,0,           1,0, 0,0,1,0, 0,0));
    tbl.push_back(mk(0,0,0,      1,0,0,           1,0, 0,0,0,0, 0,0));
    // request without grant is not accepted
    tbl.push_back(mk(0,1,32'hC,  0,0,0,           1,0, 0,1,0,0, 0,0));
    // backpressure: fill to DEPTH, full queue refuses even while popping
    tbl.push_back(mk(0,1,32'h100,1,0,0,           0,0, 1,1,0,0, 0,0));
    tbl.push_back(mk(0,1,32'h104,1,1,ins_of('h100),0,0,1,1,0,0, 1,32'h100));
    tbl.push_back(mk(0,1,32'h108,1,1,ins_of('h104),0,0,1,1,1,0, 1,32'h104));
    tbl.push_back(mk(0,1,32'h10C,1,1,ins_of('h108),0,0,1,1,1,0, 1,32'h108));
    tbl.push_back(mk(0,1,32'h110,1,1,ins_of('h10C),0,0,0,0,1,0, 1,32'h10C));
    tbl.push_back(mk(0,1,32'h110,1,0,0,           1,0, 0,0,1,0, 0,0));
    tbl.push_back(mk(0,1,32'h110,1,0,0,           0,0, 1,1,1,0, 0,0));
    tbl.push_back(mk(0,1,32'h114,1,1,ins_of('h110),0,0,0,0,1,0, 1,32'h110));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,0,    1,0,0,           1,0, 0,0,1,0, 0,0));
    tbl.push_back(mk(0,0,0,      1,0,0,           1,0, 0,0,0,0, 0,0));
    // flush with two in flight: both stale responses dropped
    tbl.push_back(mk(0,1,32'h10, 1,0,0,           1,0, 1,1,0,0, 0,0));
    tbl.push_back(mk(0,1,32'h14, 1,0,0,           1,0, 1,1,0,0, 0,0));
    tbl.push_back(mk(0,1,32'h40, 1,0,0,           1,1, 0,0,0,0, 0,0));
    tbl.push_back(mk(0,1,32'h40, 1,1,32'hDEAD0001,1,0, 1,1,0,0, 0,0));
    tbl.push_back(mk(0,0,0,      1,1,32'hDEAD0002,1,0, 0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,0,      1,1,ins_of('h40),1,0, 0,0,0,0, 1,32'h40));
    tbl.push_back(mk(0,0,0,      1,0,0,           1,0, 0,0,1,0, 0,0));
    tbl.push_back(mk(0,0,0,      1,0,0,           1,0, 0,0,0,0, 0,0));
    // flush coincident with rvalid and pop: drop_cnt ends at exactly 1
    tbl.push_back(mk(0,1,32'h20, 1,0,0,           0,0, 1,1,0,0, 0,0));
    tbl.push_back(mk(0,1,32'h24, 1,1,ins_of('h20),0,0, 1,1,0,0, 0,0));
    tbl.push_back(mk(0,1,32'h28, 1,0,0,           0,0, 1,1,1,0, 0,0));
    tbl.push_back(mk(0,0,0,      1,1,ins_of('h24),1,1, 0,0,1,0, 0,0));
    tbl.push_back(mk(0,0,0,      1,1,32'hDEAD0003,1,0, 0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,0,      1,0,0,           1,0, 0,0,0,0, 0,0));
    // stray rvalid: sticky error, nothing emitted
    tbl.push_back(mk(0,0,0,      1,1,32'hDEAD0004,1,0, 0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,0,      1,0,0,           1,0, 0,0,0,1, 0,0));
    tbl.push_back(mk(0,0,0,      1,0,0,           1,0, 0,0,0,1, 0,0));

    foreach (tbl[i]) step(tbl[i]);

    // reset mid-operation: 3 entries, 2 in flight
    step(mk(0,1,32'h200,1,0,0,            0,0, 1,1,0,1, 0,0));
    step(mk(0,1,32'h204,1,1,ins_of('h200),0,0, 1,1,0,1, 0,0));
    step(mk(0,1,32'h208,1,0,0,            0,0, 1,1,1,1, 0,0));
    step(mk(1,1,32'h20C,1,0,0,            1,0, 0,0,0,0, 0,0));
    step(mk(0,1,32'h300,1,0,0,            1,0, 1,1,0,0, 0,0));
    step(mk(0,0,0,      1,1,ins_of('h300),1,0, 0,0,0,0, 1,32'h300));
    step(mk(0,0,0,      1,0,0,            1,0, 0,0,1,0, 0,0));
    step(mk(0,0,0,      1,0,0,            1,0, 0,0,0,0, 0,0));

    chk("sb_leftover", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
